// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit byte-slot scheduler.
// Optional SKP ordered-set insertion is enabled with `define TX_SCHED_SKP_EN.
package tx_sched_pkg;

`ifdef TX_SCHED_SKP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SKP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
  } state_t;
`endif

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;

  // Reserved width code falls back to a single byte.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'b11) ? W8 : w;
  endfunction

  // Slots remaining after the first one of a frame of the given width.
  function automatic logic [1:0] extra_slots(input logic [1:0] w);
    case (w)
      W16:     return 2'd1;
      W32:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-input round-robin arbiter. Grants are combinational in the cycle
// where the scheduler allows one; the pointer remembers the last winner.
module tx_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // last1 = 1 means requester 1 won last, so requester 0 is favoured.
  logic last1;

  // Grant decode: a lone requester wins, ties go to the one not served last.
  always_comb begin
    gnt0 = en & req0 & (~req1 | last1);
    gnt1 = en & req1 & (~req0 | ~last1);
  end

  // Pointer update on every issued grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last1 <= 1'b1;
    end else if (gnt0) begin
      last1 <= 1'b0;
    end else if (gnt1) begin
      last1 <= 1'b1;
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Byte-slot transmit scheduler: sends COM while idle, grants one of two
// requesters at slot boundaries and holds its payload for 1/2/4 slots.
// Optional SKP insertion every SKP_INTERVAL frames: `define TX_SCHED_SKP_EN.
//
// state   | meaning
// IDLE    | sending COM (K=1, 8'hBC)
// DATA    | holding captured payload for 1/2/4 slots
// SKP     | one slot of SKP (K=1, 8'h1C), only with TX_SCHED_SKP_EN
module tx_sched #(
  parameter int SLOT_CYCLES  = 10,
  parameter int SKP_INTERVAL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  w0,
  input  logic [1:0]  w1,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        K,
  output logic [1:0]  dataS,
  output logic [7:0]  dataIn,
  output logic [15:0] dataIn16,
  output logic [31:0] dataIn32,
  output logic        busy
);
  import tx_sched_pkg::*;

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

  if (SLOT_CYCLES < 2) begin : g_bad_slot
    $error("SLOT_CYCLES must be at least 2");
  end
  if (SKP_INTERVAL < 1) begin : g_bad_interval
    $error("SKP_INTERVAL must be at least 1");
  end

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    slots_left;
  logic          decision;
  logic          frame_done;
  logic          skp_due;
  logic          arb_en;
  logic          gnt;
  logic [1:0]    sel_w;
  logic [31:0]   sel_d;

`ifdef TX_SCHED_SKP_EN
  localparam int XW = $clog2(SKP_INTERVAL + 1);
  logic [XW-1:0] xfer_cnt;
`endif

  // Decision-point decode and selection of the winning requester's payload.
  always_comb begin
    decision   = enb && (slot_cnt == SLOT_LAST);
    frame_done = (state != ST_DATA) || (slots_left == 2'd0);
`ifdef TX_SCHED_SKP_EN
    skp_due    = (xfer_cnt >= XW'(SKP_INTERVAL));
`else
    skp_due    = 1'b0;
`endif
    arb_en     = decision && frame_done && !skp_due;
    gnt        = gnt0 | gnt1;
    sel_w      = norm_width(gnt0 ? w0 : w1);
    sel_d      = gnt0 ? d0 : d1;
  end

  tx_rr_arbiter u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Slot timing, state and registered transmitter outputs; all frozen while enb=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      slot_cnt   <= '0;
      slots_left <= 2'd0;
      busy       <= 1'b0;
      K          <= 1'b1;
      dataS      <= W8;
      dataIn     <= COM;
      dataIn16   <= 16'h0000;
      dataIn32   <= 32'h0000_0000;
`ifdef TX_SCHED_SKP_EN
      xfer_cnt   <= '0;
`endif
    end else if (enb) begin
      slot_cnt <= decision ? '0 : slot_cnt + CW'(1);
      if (decision) begin
        if (!frame_done) begin
          slots_left <= slots_left - 2'd1;
`ifdef TX_SCHED_SKP_EN
        end else if (skp_due) begin
          state    <= ST_SKP;
          busy     <= 1'b1;
          K        <= 1'b1;
          dataS    <= W8;
          dataIn   <= SKP;
          xfer_cnt <= '0;
`endif
        end else if (gnt) begin
          state      <= ST_DATA;
          busy       <= 1'b1;
          K          <= 1'b0;
          dataS      <= sel_w;
          slots_left <= extra_slots(sel_w);
          case (sel_w)
            W16:     dataIn16 <= sel_d[15:0];
            W32:     dataIn32 <= sel_d;
            default: dataIn   <= sel_d[7:0];
          endcase
`ifdef TX_SCHED_SKP_EN
          xfer_cnt <= xfer_cnt + XW'(1);
`endif
        end else begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          K      <= 1'b1;
          dataS  <= W8;
          dataIn <= COM;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Scoreboard bench for tx_sched: directed stimulus pushes expected grants
// and busy frames; a negedge monitor pops and compares as the DUT emits them.
module tb_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  w0 = 2'b00, w1 = 2'b00;
  logic [31:0] d0 = '0, d1 = '0;
  logic        gnt0, gnt1, K, busy;
  logic [1:0]  dataS;
  logic [7:0]  dataIn;
  logic [15:0] dataIn16;
  logic [31:0] dataIn32;

  tx_sched #(.SLOT_CYCLES(10), .SKP_INTERVAL(2)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .req0(req0), .req1(req1), .w0(w0), .w1(w1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .K(K), .dataS(dataS),
    .dataIn(dataIn), .dataIn16(dataIn16), .dataIn32(dataIn32), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cyc; } gexp_t;
  typedef struct { logic k; logic [1:0] s; logic [31:0] v; int len; } sexp_t;

  gexp_t gq[$];
  sexp_t sq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_g(input int id, input int c);
    gexp_t g;
    g.id = id; g.cyc = c;
    gq.push_back(g);
  endtask

  task automatic push_s(input logic k, input logic [1:0] s, input logic [31:0] v, input int len);
    sexp_t e;
    e.k = k; e.s = s; e.v = v; e.len = len;
    sq.push_back(e);
  endtask

  // cycle index since reset release; equals the slot count while enb stays high
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor
  logic        run_on = 1'b0;
  logic        run_k;
  logic [1:0]  run_s;
  logic [31:0] run_v;
  int          run_len = 0;
  logic        prev_g = 1'b0;
  logic [31:0] cur_v;
  gexp_t       g_pop;
  sexp_t       s_pop;

  always @(negedge clk) begin
    case (dataS)
      2'b00:   cur_v = {24'h0, dataIn};
      2'b01:   cur_v = {16'h0, dataIn16};
      default: cur_v = dataIn32;
    endcase
    if (gnt0 && gnt1) chk("gnt_onehot", 32'd3, 32'd1);
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_gnt: got gnt1=%0b at cyc %0d want none", gnt1, cyc);
      end else begin
        g_pop = gq.pop_front();
        chk("gnt_id", {31'h0, gnt1}, g_pop.id);
        chk("gnt_cyc", cyc, g_pop.cyc);
      end
    end
    if (run_on && (!busy || K != run_k || dataS != run_s || cur_v != run_v || prev_g)) begin
      run_on = 1'b0;
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame: got val %0h len %0d want none", run_v, run_len);
      end else begin
        s_pop = sq.pop_front();
        chk("frame_k", {31'h0, run_k}, {31'h0, s_pop.k});
        chk("frame_sel", {30'h0, run_s}, {30'h0, s_pop.s});
        chk("frame_val", run_v, s_pop.v);
        chk("frame_len", run_len, s_pop.len);
      end
    end
    if (busy) begin
      if (!run_on) begin
        run_on = 1'b1; run_k = K; run_s = dataS; run_v = cur_v; run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      chk("idle_k", {31'h0, K}, 32'd1);
      chk("idle_sel", {30'h0, dataS}, 32'd0);
      chk("idle_com", {24'h0, dataIn}, 32'hBC);
    end
    prev_g = gnt0 | gnt1;
  end

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; enb = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", {31'h0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'h0, gnt1}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_k", {31'h0, K}, 32'd1);
    chk("rst_sel", {30'h0, dataS}, 32'd0);
    chk("rst_com", {24'h0, dataIn}, 32'hBC);
    chk("rst_d16", {16'h0, dataIn16}, 32'd0);
    chk("rst_d32", dataIn32, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // idle after reset: only COM, no grants
    do_reset();
    run_to(30);

    // single 8b transfer
    do_reset();
    req0 = 1'b1; w0 = 2'b00; d0 = 32'h0000_0025;
    push_g(0, 9); push_s(1'b0, 2'b00, 32'h25, 10);
    run_to(10); req0 = 1'b0;
    run_to(30);

    // single 16b transfer from requester 1, buses outside the frame hold
    do_reset();
    req1 = 1'b1; w1 = 2'b01; d1 = 32'h5555_ABCD;
    push_g(1, 9); push_s(1'b0, 2'b01, 32'hABCD, 20);
    run_to(10); req1 = 1'b0;
    run_to(15);
    chk("d16_hold_d8", {24'h0, dataIn}, 32'hBC);
    chk("d16_hold_d32", dataIn32, 32'd0);
    run_to(40);
    chk("d16_after", {16'h0, dataIn16}, 32'hABCD);

    // both requesting 32b: round-robin 0,1,0
    do_reset();
    req0 = 1'b1; req1 = 1'b1; w0 = 2'b10; w1 = 2'b10;
    d0 = 32'h0123_456F; d1 = 32'hDEAD_BEEF;
    push_g(0, 9); push_g(1, 49); push_g(0, 89);
    push_s(1'b0, 2'b10, 32'h0123_456F, 40);
    push_s(1'b0, 2'b10, 32'hDEAD_BEEF, 40);
    push_s(1'b0, 2'b10, 32'h0123_456F, 40);
    run_to(60);
    chk("d32_hold_d8", {24'h0, dataIn}, 32'hBC);
    run_to(90); req0 = 1'b0; req1 = 1'b0;
    run_to(140);

    // enable dropped 15 cycles mid 32b frame
    do_reset();
    req0 = 1'b1; w0 = 2'b10; d0 = 32'hCAFE_F00D;
    push_g(0, 9); push_s(1'b0, 2'b10, 32'hCAFE_F00D, 55);
    run_to(10); req0 = 1'b0;
    run_to(20); enb = 1'b0;
    repeat (15) @(posedge clk);
    #1 enb = 1'b1;
    run_to(80);

    // reserved width captured as 8b
    do_reset();
    req0 = 1'b1; w0 = 2'b11; d0 = 32'h1234_56A7;
    push_g(0, 9); push_s(1'b0, 2'b00, 32'hA7, 10);
    run_to(10); req0 = 1'b0;
    run_to(30);

    // enb low suppresses grants; slot count resumes where it stopped
    do_reset();
    run_to(5); enb = 1'b0;
    req1 = 1'b1; w1 = 2'b00; d1 = 32'h0000_0066;
    push_g(1, 29); push_s(1'b0, 2'b00, 32'h66, 10);
    run_to(25); enb = 1'b1;
    run_to(30); req1 = 1'b0;
    run_to(50);

    // reset mid-frame aborts it
    do_reset();
    req0 = 1'b1; w0 = 2'b10; d0 = 32'h1122_3344;
    push_g(0, 9); push_s(1'b0, 2'b10, 32'h1122_3344, 10);
    run_to(10); req0 = 1'b0;
    run_to(19);
    do_reset();
    run_to(30);

`ifdef TX_SCHED_SKP_EN
    // SKP every 2 frames with continuous 8b requests
    do_reset();
    req0 = 1'b1; w0 = 2'b00; d0 = 32'h0000_005A;
    push_g(0, 9); push_g(0, 19); push_g(0, 39); push_g(0, 49); push_g(0, 69);
    push_s(1'b0, 2'b00, 32'h5A, 10);
    push_s(1'b0, 2'b00, 32'h5A, 10);
    push_s(1'b1, 2'b00, 32'h1C, 10);
    push_s(1'b0, 2'b00, 32'h5A, 10);
    push_s(1'b0, 2'b00, 32'h5A, 10);
    push_s(1'b1, 2'b00, 32'h1C, 10);
    push_s(1'b0, 2'b00, 32'h5A, 10);
    run_to(70); req0 = 1'b0;
    run_to(100);
`endif

    repeat (5) @(negedge clk);
    chk("gnt_queue_empty", gq.size(), 32'd0);
    chk("frame_queue_empty", sq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish by t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
